// File: rtl/srlatch_ctrl_pkg.sv
// Shared types and helpers for the SR latch sequencer.
package srlatch_ctrl_pkg;

    typedef enum logic [1:0] {
        StInit  = 2'd0,
        StIdle  = 2'd1,
        StPulse = 2'd2,
        StGap   = 2'd3
    } state_e;

    localparam logic CMD_CLR = 1'b0;
    localparam logic CMD_SET = 1'b1;

    // Counters are loaded with (cycles - 1), so log2 of the longer phase is enough.
    function automatic int unsigned cnt_width(input int unsigned pulse_cyc,
                                              input int unsigned gap_cyc);
        int unsigned max_cyc;
        max_cyc = (pulse_cyc > gap_cyc) ? pulse_cyc : gap_cyc;
        return (max_cyc > 1) ? $clog2(max_cyc) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer flips to the other side after each grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o[0] = en_i & req_i[0] & (~req_i[1] | ~ptr_q);
        gnt_o[1] = en_i & req_i[1] & (~req_i[0] | ptr_q);
        ptr_d    = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/srlatch_ctrl.sv
// SR latch sequencer: arbitrates set/clear commands and drives guarded S/R pulses.
// Optional SRLATCH_CTRL_ELIDE_EN: commands matching the tracked state are acked without a pulse.
module srlatch_ctrl
    import srlatch_ctrl_pkg::*;
#(
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned GAP_CYC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req0_valid,
    input  logic req0_cmd,
    output logic req0_ready,
    input  logic req1_valid,
    input  logic req1_cmd,
    output logic req1_ready,
    output logic s,
    output logic r,
    input  logic q_sense,
    output logic q_state,
    output logic busy,
    output logic err
);

    localparam int unsigned     CntW      = cnt_width(PULSE_CYC, GAP_CYC);
    localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYC - 1);
    localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYC - 1);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              s_q, s_d, r_q, r_d;
    logic              cmd_q, cmd_d;
    logic              q_state_q, q_state_d;
    logic              err_q, err_d;
    logic [1:0]        gnt;
    logic              accept;
    logic              cmd_sel;
    logic              elide;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == StIdle),
        .req_i ({req1_valid, req0_valid}),
        .gnt_o (gnt)
    );

    assign accept  = |gnt;
    assign cmd_sel = gnt[1] ? req1_cmd : req0_cmd;

`ifdef SRLATCH_CTRL_ELIDE_EN
    assign elide = accept & (cmd_sel == q_state_q);
`else
    assign elide = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        r_d       = r_q;
        cmd_d     = cmd_q;
        q_state_d = q_state_q;
        err_d     = err_q;
        unique case (state_q)
            StInit: begin
                // First INIT cycle out of reset has r low; raise it and start counting.
                if (!r_q) begin
                    r_d   = 1'b1;
                    cnt_d = PulseLoad;
                end else if (cnt_q == '0) begin
                    r_d       = 1'b0;
                    q_state_d = CMD_CLR;
                    cnt_d     = GapLoad;
                    state_d   = StGap;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StIdle: begin
                if (accept && !elide) begin
                    cmd_d   = cmd_sel;
                    s_d     = (cmd_sel == CMD_SET);
                    r_d     = (cmd_sel == CMD_CLR);
                    cnt_d   = PulseLoad;
                    state_d = StPulse;
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    s_d       = 1'b0;
                    r_d       = 1'b0;
                    q_state_d = cmd_q;
                    cnt_d     = GapLoad;
                    state_d   = StGap;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    if (q_sense != q_state_q) begin
                        err_d = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                s_d     = 1'b0;
                r_d     = 1'b0;
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            cmd_q     <= CMD_CLR;
            q_state_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            r_q       <= r_d;
            cmd_q     <= cmd_d;
            q_state_q <= q_state_d;
            err_q     <= err_d;
        end
    end

    assign s          = s_q;
    assign r          = r_q;
    assign q_state    = q_state_q;
    assign err        = err_q;
    assign busy       = (state_q != StIdle);
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

endmodule

// File: tb/tb_srlatch_ctrl.sv
// Directed bench for srlatch_ctrl with a clocked behavioural SR latch on q_sense.
module tb_srlatch_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req0_cmd, req0_ready;
    logic req1_valid, req1_cmd, req1_ready;
    logic s, r, q_sense, q_state, busy, err;
    logic lq = 1'b0;
    logic q_fault;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s) begin
            lq <= 1'b1;
        end else if (r) begin
            lq <= 1'b0;
        end
    end

    assign q_sense = q_fault ? 1'b0 : lq;

    srlatch_ctrl #(
        .PULSE_CYC (2),
        .GAP_CYC   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_cmd   (req0_cmd),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_cmd   (req1_cmd),
        .req1_ready (req1_ready),
        .s          (s),
        .r          (r),
        .q_sense    (q_sense),
        .q_state    (q_state),
        .busy       (busy),
        .err        (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One reset cycle, then the full INIT sequence back to IDLE.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [3:0] exp_r    = 4'b0011;
        logic [3:0] exp_busy = 4'b0111;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({s, r, busy, err, q_state} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_outputs: got s,r,busy,err,q=%b want 00100",
                     {s, r, busy, err, q_state});
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (r !== exp_r[i] || s !== 1'b0 || busy !== exp_busy[i]) begin
                errors++;
                $display("FAIL reset_init_seq[%0d]: got s=%b r=%b busy=%b want s=0 r=%b busy=%b",
                         i, s, r, busy, exp_r[i], exp_busy[i]);
            end
        end
        checks++;
        if ({q_state, err, q_sense} !== 3'b000) begin
            errors++;
            $display("FAIL reset_final: got q_state,err,q_sense=%b want 000",
                     {q_state, err, q_sense});
        end
    endtask

    task automatic test_set_clear();
        logic [3:0] exp_s = 4'b0011;
        req0_valid = 1'b1;
        req0_cmd   = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL set_ready: got %b want 10", {req0_ready, req1_ready});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            req0_valid = 1'b0;
            checks++;
            if (s !== exp_s[k] || r !== 1'b0) begin
                errors++;
                $display("FAIL set_pulse[%0d]: got s=%b r=%b want s=%b r=0", k, s, r, exp_s[k]);
            end
        end
        checks++;
        if ({busy, q_state, err} !== 3'b010) begin
            errors++;
            $display("FAIL set_done: got busy,q,err=%b want 010", {busy, q_state, err});
        end
        req0_valid = 1'b1;
        req0_cmd   = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_ready: got %b want 1", req0_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            req0_valid = 1'b0;
            checks++;
            if (r !== exp_s[k] || s !== 1'b0) begin
                errors++;
                $display("FAIL clear_pulse[%0d]: got s=%b r=%b want s=0 r=%b", k, s, r, exp_s[k]);
            end
        end
        checks++;
        if ({busy, q_state, err} !== 3'b000) begin
            errors++;
            $display("FAIL clear_done: got busy,q,err=%b want 000", {busy, q_state, err});
        end
    endtask

    task automatic test_contention();
        logic gi;
        do_reset();
        req0_valid = 1'b1;
        req0_cmd   = 1'b1;
        req1_valid = 1'b1;
        req1_cmd   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gi = i[0];
            #1;
            checks++;
            if (req0_ready !== ~gi || req1_ready !== gi) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got ready0=%b ready1=%b want %b %b",
                         i, req0_ready, req1_ready, ~gi, gi);
            end
            for (int k = 1; k <= 4; k++) begin
                tick();
                checks++;
                if ((s & r) !== 1'b0 || s !== (!gi && k <= 2) || r !== (gi && k <= 2)) begin
                    errors++;
                    $display("FAIL contention_drive[%0d.%0d]: got s=%b r=%b want s=%b r=%b",
                             i, k, s, r, (!gi && k <= 2), (gi && k <= 2));
                end
                if (k < 4) begin
                    checks++;
                    if ({req0_ready, req1_ready} !== 2'b00) begin
                        errors++;
                        $display("FAIL contention_busy_ready[%0d.%0d]: got %b want 00",
                                 i, k, {req0_ready, req1_ready});
                    end
                end
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if ({q_state, err, busy} !== 3'b000) begin
            errors++;
            $display("FAIL contention_end: got q,err,busy=%b want 000", {q_state, err, busy});
        end
    endtask

    task automatic test_fault();
        q_fault    = 1'b1;
        req0_valid = 1'b1;
        req0_cmd   = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL fault_gap_err: got %b want 0", err);
        end
        tick();
        checks++;
        if ({err, busy, q_state} !== 3'b101) begin
            errors++;
            $display("FAIL fault_err_set: got err,busy,q=%b want 101", {err, busy, q_state});
        end
        req0_valid = 1'b1;
        req0_cmd   = 1'b0;
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if ({err, q_state} !== 2'b10) begin
            errors++;
            $display("FAIL fault_sticky: got err,q=%b want 10", {err, q_state});
        end
        q_fault = 1'b0;
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL fault_cleared_by_rst: got %b want 0", err);
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [3:0] exp_r = 4'b0110;
        req0_valid = 1'b1;
        req0_cmd   = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        checks++;
        if (s !== 1'b1) begin
            errors++;
            $display("FAIL midpulse_s_high: got %b want 1", s);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({s, r, busy, q_state} !== 4'b0010) begin
            errors++;
            $display("FAIL midpulse_truncated: got s,r,busy,q=%b want 0010", {s, r, busy, q_state});
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (r !== exp_r[k] || s !== 1'b0) begin
                errors++;
                $display("FAIL midpulse_init[%0d]: got s=%b r=%b want s=0 r=%b", k, s, r, exp_r[k]);
            end
            tick();
        end
        req0_valid = 1'b1;
        req0_cmd   = 1'b1;
        req1_valid = 1'b1;
        req1_cmd   = 1'b0;
        #1;
        checks++;
        if ({busy, req0_ready, req1_ready} !== 3'b010) begin
            errors++;
            $display("FAIL midpulse_ptr: got busy,ready0,ready1=%b want 010",
                     {busy, req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_back_to_back_set();
        req0_valid = 1'b1;
        req0_cmd   = 1'b1;
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy, q_state} !== 2'b01) begin
            errors++;
            $display("FAIL set2_first: got busy,q=%b want 01", {busy, q_state});
        end
        req1_valid = 1'b1;
        req1_cmd   = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL set2_ready: got %b want 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
`ifdef SRLATCH_CTRL_ELIDE_EN
        checks++;
        if ({s, busy, q_state} !== 3'b001) begin
            errors++;
            $display("FAIL set2_elided: got s,busy,q=%b want 001", {s, busy, q_state});
        end
`else
        checks++;
        if ({s, busy} !== 2'b11) begin
            errors++;
            $display("FAIL set2_pulse1: got s,busy=%b want 11", {s, busy});
        end
        tick();
        checks++;
        if (s !== 1'b1) begin
            errors++;
            $display("FAIL set2_pulse2: got s=%b want 1", s);
        end
        tick();
        tick();
`endif
        checks++;
        if ({s, r, busy, q_state, err} !== 5'b00010) begin
            errors++;
            $display("FAIL set2_end: got s,r,busy,q,err=%b want 00010", {s, r, busy, q_state, err});
        end
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req0_cmd   = 1'b0;
        req1_valid = 1'b0;
        req1_cmd   = 1'b0;
        q_fault    = 1'b0;
        test_reset();
        test_set_clear();
        test_contention();
        test_fault();
        test_reset_mid_pulse();
        test_back_to_back_set();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/srlatch_ctrl.md
Name: srlatch_ctrl

Overview:
Clocked sequencer that owns one SR latch (`s`/`r` in, `q1` out) and shares it between two requesters.
- Arbitrates set/clear commands round-robin.
- Drives fixed-width S or R pulses followed by a guard gap.
- Guarantees S and R are never high together.
- Tracks the expected latch state and flags mismatches against the latch output.

Parameters:
PULSE_CYC, 2, cycles S or R is held high per command (>=1)
GAP_CYC, 1, cycles both S and R are held low after each pulse (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a command
req0_cmd  input  1  requester 0 command: 1 = set, 0 = clear
req0_ready  output  1  requester 0 command accepted this cycle
req1_valid  input  1  requester 1 has a command
req1_cmd  input  1  requester 1 command: 1 = set, 0 = clear
req1_ready  output  1  requester 1 command accepted this cycle
s  output  1  latch set drive (registered)
r  output  1  latch reset drive (registered)
q_sense  input  1  latch q1, already synchronized to clk
q_state  output  1  tracked latch value
busy  output  1  high in any state other than IDLE
err  output  1  sticky: sensed value differed from expected

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high. When `rst` is sampled high:
  - next cycle: s=0, r=0, req*_ready=0, q_state=0, err=0, busy=1
  - round-robin pointer resets to requester 0
  - state goes to INIT
  - this also applies mid-pulse: the pulse is truncated and no partial state is kept.
- States: INIT, IDLE, PULSE, GAP.
- INIT (first state after reset):
  - drives r=1 for PULSE_CYC cycles, then GAP, then IDLE
  - puts the latch in a known cleared state
  - no commands are accepted.
- IDLE and arbitration:
  - In IDLE, exactly one ready may be high, combinationally from the valids.
  - With a single valid, that requester wins.
  - With both valid, the pointer's requester wins.
  - Transfer happens when valid & ready.
  - After a grant, the pointer moves to the other requester.
  - Requesters hold valid and cmd stable until accepted.
- Accept at cycle T:
  - cmd is latched
  - s (cmd=1) or r (cmd=0) is high on cycles T+1 .. T+PULSE_CYC (state PULSE, down-counter)
  - GAP follows on cycles T+PULSE_CYC+1 .. T+PULSE_CYC+GAP_CYC with s=r=0
  - IDLE is re-entered at T+PULSE_CYC+GAP_CYC+1, where the next accept is possible
  - throughput: one command per PULSE_CYC+GAP_CYC+1 cycles.
- q_state:
  - updates to the latched cmd on the first GAP cycle
  - in INIT it is cleared at the same point.
- Check:
  - on the last GAP cycle, q_sense is compared with q_state
  - on mismatch, err is set
  - err stays set until rst.
- Invariant: s & r == 0 in every cycle, including across reset and INIT.
- busy=0 only in IDLE. ready is 0 whenever busy=1.
- Counter widths are sized to max(PULSE_CYC, GAP_CYC).
- No command queuing: a valid seen while busy simply waits.

Optional Feature:
- Macro: SRLATCH_CTRL_ELIDE_EN.
- When defined:
  - a command accepted in IDLE whose cmd equals q_state is acknowledged with no PULSE/GAP
  - the controller stays in IDLE
  - the next accept may happen on the following cycle
  - no err check is made for that command.
- When undefined:
  - every accepted command produces the full pulse/gap sequence and its check.

Decomposition:
- Package srlatch_ctrl_pkg holds:
  - state encoding (INIT, IDLE, PULSE, GAP)
  - CMD_CLR=1'b0 and CMD_SET=1'b1
  - a helper function computing counter width from PULSE_CYC/GAP_CYC.
- Sub-module rr_arb2 is a natural split: a 2-requester round-robin arbiter with grant-enable and pointer update on accept.
- The FSM and counters stay in srlatch_ctrl.

Test Plan:
1. Reset, defaults: rst for 2 cycles then release -> r=1 for exactly 2 cycles, s=0 throughout, 1 gap cycle, then busy=0, q_state=0, err=0, q_sense from the behavioural latch =0.
2. Set then clear, requester 0: req0 set accepted at T -> s=1 at T+1..T+2, q_state=1 at T+3, ready possible at T+4. Clear at T+4 -> r=1 at T+5..T+6, q_state=0.
3. Contention: both valid every cycle from IDLE, req0=set, req1=clear -> grants alternate 0,1,0,1 exactly, and s&r==0 on every cycle.
4. Fault: tie q_sense=0, issue set -> err=1 after the gap. A later clear leaves err=1 until rst.
5. Reset mid-pulse: assert rst on the 2nd cycle of s=1 -> s=0 next cycle, then INIT clear pulse, pointer back to requester 0.
6. With SRLATCH_CTRL_ELIDE_EN: set, then set again -> second command acked with no s pulse and busy stays 0. Without the macro -> second command produces a full 2-cycle s pulse.
